// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC,
// fetch FSM encoding and the prefetch buffer entry layout.
package core_pkg;

  localparam int PC_W   = 10;
  localparam int DATA_W = 32;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // One buffered instruction: the word plus the PC it was fetched from.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Word-address increment; wraps naturally from 2**PC_W-1 to 0.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundle of the fetch stage: request/response channel to
// instruction memory and the instruction stream to the decoder.
interface fetch_unit_if;
  import core_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;

  // Fetch unit side.
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  // Memory/decoder side.
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO. The head entry is mirrored in a register so the decoder
// sees it with no read latency. Flush wins over a same-cycle push.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  // Storage array; contents need no reset, only the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Head register tracks mem[rd_ptr]; a push into an (about to be) empty
  // FIFO bypasses straight into it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
    end else if (!flush) begin
      if (do_push && (empty || (count == CW'(1) && do_pop))) begin
        head <= push_data;
      end else if (do_pop && count > CW'(1)) begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most DEPTH words
// either in flight or buffered, tags returned words with their PC and
// discards responses made stale by a redirect.
module fetch_unit
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  fetch_unit_if.master    bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = CW + 1;

  fetch_state_e  state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [BW-1:0] budget;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          accept;
  logic          keep;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign pop = ~fifo_empty & bus.inst_ready;

  // Slots already claimed: buffered words plus requests still in flight,
  // less the one leaving this cycle.
  assign budget = {1'b0, fifo_count} + {1'b0, outstanding} - BW'(pop);

  assign bus.imem_req_valid = (state == RUN) & ~redirect_valid & (budget < BW'(DEPTH));
  assign bus.imem_addr      = pc;

  assign accept           = bus.imem_req_valid & bus.imem_req_ready;
  assign outstanding_next = outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
  assign keep             = bus.imem_rsp_valid & (drop == '0);

  assign push_entry.data = bus.imem_rsp_data;
  assign push_entry.pc   = rsp_pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_data  = head.data;
  assign bus.inst_pc    = head.pc;

  // Fetch FSM: run while fetching is enabled; in-flight words still land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (fetch_en)  state <= RUN;
        RUN:  if (!fetch_en) state <= IDLE;
      endcase
    end
  end

  // PC, response tag and in-flight bookkeeping. On a redirect every
  // request still in flight after this cycle is stale, so the drop count
  // becomes exactly that number (never more than DEPTH).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        rsp_pc <= redirect_pc;
        drop   <= outstanding_next;
      end else begin
        if (accept) pc <= pc_inc(pc);
        if (keep) begin
          rsp_pc <= pc_inc(rsp_pc);
        end else if (bus.imem_rsp_valid) begin
          drop <= drop - 1'b1;
        end
      end
    end
  end

  // A kept word can only meet a full buffer if the issue rule was broken.
  assert property (@(posedge clk) disable iff (!reset)
    !(keep && !redirect_valid && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all checked against a transaction-level model of the
// expected instruction stream and memory traffic.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_en = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [9:0] redirect_pc = '0;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory model: accepted addresses, their acceptance cycle, stale flag.
  logic [9:0] addr_q [$];
  int         time_q [$];
  bit         stale_q [$];

  // Expected stream state.
  int         fifo_m = 0;
  logic [9:0] exp_pc = '0;
  logic [9:0] exp_addr = '0;

  int mem_lat   = 1;
  bit mem_rand  = 1'b0;
  bit dec_rand  = 1'b0;
  bit dec_ready = 1'b1;

  bit last_acc, last_pop, last_rsp, last_req;
  int acc_cyc [$];
  int pop_cyc [$];
  int pop_pc_q [$];
  int n_acc = 0;

  function automatic logic [31:0] mdata(input logic [9:0] a);
    return 32'hC0DE0000 ^ ({22'd0, a} * 32'd2654435761);
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // then advance the model by the handshakes that the next rising edge takes.
  task automatic cycle(input bit rd = 1'b0, input logic [9:0] rpc = '0);
    bit run_m, rsp_now, rsp_stale, acc, pop_m, dut_pop, req_exp;
    int infl;
    @(negedge clk);
    cyc++;
    run_m = fetch_en;
    redirect_valid = rd;
    redirect_pc    = rpc;
    infl      = addr_q.size();
    rsp_now   = 1'b0;
    rsp_stale = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (infl > 0 && cyc >= time_q[0] + mem_lat && (!mem_rand || $urandom_range(0, 2) != 0)) begin
      rsp_now   = 1'b1;
      rsp_stale = stale_q[0];
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mdata(addr_q[0]);
      void'(addr_q.pop_front());
      void'(time_q.pop_front());
      void'(stale_q.pop_front());
    end
    bus.imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.inst_ready     = dec_rand ? 1'($urandom_range(0, 1)) : dec_ready;
    #1;
    pop_m   = (fifo_m > 0) && bus.inst_ready;
    req_exp = run_m && !rd && (fifo_m + infl - int'(pop_m) < 4);
    chk("inst_valid", bus.inst_valid, fifo_m > 0);
    chk("req_valid", bus.imem_req_valid, req_exp);
    acc     = bus.imem_req_valid && bus.imem_req_ready;
    dut_pop = bus.inst_valid && bus.inst_ready;
    if (acc) begin
      chk("imem_addr", bus.imem_addr, exp_addr);
      addr_q.push_back(bus.imem_addr);
      time_q.push_back(cyc);
      stale_q.push_back(1'b0);
      exp_addr++;
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    if (dut_pop) begin
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst_data", bus.inst_data, mdata(exp_pc));
      pop_cyc.push_back(cyc);
      pop_pc_q.push_back(int'(bus.inst_pc));
      exp_pc++;
    end
    if (pop_m) fifo_m--;
    if (rsp_now && !rsp_stale) fifo_m++;
    if (rd) begin
      fifo_m = 0;
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      exp_pc   = rpc;
      exp_addr = rpc;
    end
    last_acc = acc;
    last_pop = dut_pop;
    last_rsp = rsp_now;
    last_req = bus.imem_req_valid;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    fetch_en  = 1'b0;
    dec_ready = 1'b1;
    while ((addr_q.size() != 0 || fifo_m != 0) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, n < 40, 1'b1);
    cycle();
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    pop_cyc.delete();
    pop_pc_q.delete();
    n_acc = 0;
  endtask

  initial begin
    bit found;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 10'h0);
    repeat (3) @(negedge clk);
    chk("rst_hold_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_hold_inst_valid", bus.inst_valid, 1'b0);

    // 1: streaming with a zero-wait, 1-cycle memory
    reset    = 1'b1;
    fetch_en = 1'b1;
    clear_logs();
    repeat (10) cycle();
    chk("t1_first_acc", qget(acc_cyc, 0), 1);
    chk("t1_acc_back2back", qget(acc_cyc, 3) - qget(acc_cyc, 0), 3);
    chk("t1_latency", qget(pop_cyc, 0) - qget(acc_cyc, 0), 2);
    chk("t1_pop_rate", qget(pop_cyc, 3) - qget(pop_cyc, 0), 3);
    for (int i = 0; i < 4; i++) chk("t1_pc_seq", qget(pop_pc_q, i), i);

    // 2: decoder stalled, issue limited to DEPTH
    drain("t2_drain");
    clear_logs();
    dec_ready = 1'b0;
    fetch_en  = 1'b1;
    repeat (12) cycle();
    chk("t2_n_issued", n_acc, 4);
    chk("t2_req_blocked", last_req, 1'b0);
    dec_ready = 1'b1;
    cycle();
    chk("t2_resume_pop", last_pop, 1'b1);
    chk("t2_resume_acc", last_acc, 1'b1);

    // 3: redirect with 2 in flight and 1 buffered
    drain("t3_drain");
    mem_lat   = 2;
    dec_ready = 1'b0;
    fetch_en  = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (addr_q.size() == 2 && fifo_m == 1) found = 1'b1;
    end
    chk("t3_setup", found, 1'b1);
    clear_logs();
    cycle(1'b1, 10'h200);
    dec_ready = 1'b1;
    cycle();
    chk("t3_flushed", bus.inst_valid, 1'b0);
    for (int i = 0; i < 20 && pop_pc_q.size() == 0; i++) cycle();
    chk("t3_first_pc", qget(pop_pc_q, 0), 'h200);

    // 4: redirect colliding with a response and a pop
    mem_lat = 1;
    repeat (6) cycle();
    clear_logs();
    cycle(1'b1, 10'h123);
    chk("t4_pop_done", last_pop, 1'b1);
    chk("t4_rsp_seen", last_rsp, 1'b1);
    chk("t4_pop_pc_old", qget(pop_pc_q, 0) != 'h123, 1'b1);
    pop_pc_q.delete();
    repeat (10) cycle();
    chk("t4_first_pc", qget(pop_pc_q, 0), 'h123);

    // 5: PC wrap
    cycle(1'b1, 10'h3FE);
    clear_logs();
    repeat (8) cycle();
    chk("t5_pc0", qget(pop_pc_q, 0), 'h3FE);
    chk("t5_pc1", qget(pop_pc_q, 1), 'h3FF);
    chk("t5_pc2", qget(pop_pc_q, 2), 'h000);

    // 6: asynchronous reset in the middle of a burst
    chk("t6_busy", bus.inst_valid, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_req_valid", bus.imem_req_valid, 1'b0);
    chk("t6_inst_valid", bus.inst_valid, 1'b0);
    chk("t6_inst_data", bus.inst_data, 32'h0);
    chk("t6_inst_pc", bus.inst_pc, 10'h0);
    addr_q.delete();
    time_q.delete();
    stale_q.delete();
    fifo_m   = 0;
    exp_pc   = '0;
    exp_addr = '0;
    repeat (2) @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    reset = 1'b1;
    clear_logs();
    repeat (8) cycle();
    chk("t6_restart_pc", qget(pop_pc_q, 0), 0);

    // Randomized traffic: stalls on both sides, random redirects
    mem_rand = 1'b1;
    dec_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      logic [9:0] rpc;
      rd  = ($urandom_range(0, 19) == 0);
      rpc = 10'($urandom);
      if ($urandom_range(0, 49) == 0) fetch_en = ~fetch_en;
      cycle(rd, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
